adjust_button_pulser: RTL and testbench

Front-end pulse generator for the alarm clock's time-set path: turns the raw, bouncing up/down push-buttons into clean single-cycle `count_up` / `count_down` strobes that drive the modulo digit counters' adjust inputs. It synchronises and debounces each button, emits one strobe per press, and auto-repeats while a button is held. It sits between the board buttons and the hour/minute/second counter chain, in the same `clk` domain as the counters.

---
 rtl/adjust_button_pulser.sv | 136 +++++++++++++
 tb/tb_adjust_button_pulser.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adjust_button_pulser.sv
// Up/down button front end: two-flop synchronisers, per-button debounce, and a
// single press/hold/auto-repeat FSM producing one-cycle count_up/count_down strobes.
module adjust_button_pulser #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic btn_up,
   input  logic btn_down,
   output logic count_up,
   output logic count_down,
   output logic repeating
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam int TW  = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]  REP_LAST  = TW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   // Bit 0 is the up button, bit 1 the down button throughout.
   logic [1:0]     w_raw;
   logic [1:0]     r_sync1;
   logic [1:0]     r_sync2;
   logic [1:0]     r_db;
   logic [1:0]     r_prev;
   logic [DBW-1:0] r_db_cnt [2];
   logic [1:0]     w_press;

   state_t         r_state;
   dir_t           r_dir;
   logic [TW-1:0]  r_timer;
   logic           w_dir_lvl;
   logic           w_oth_lvl;
   logic           w_abort;

   assign w_raw   = {btn_down, btn_up};
   assign w_press = r_db & ~r_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_db        <= '0;
         r_prev      <= '0;
         r_db_cnt[0] <= '0;
         r_db_cnt[1] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_prev  <= r_db;
         for (int unsigned b = 0; b < 2; b++) begin
            if (r_sync2[b] == r_db[b]) begin
               r_db_cnt[b] <= '0;
            end else if (r_db_cnt[b] == DB_LAST) begin
               r_db[b]     <= r_sync2[b];
               r_db_cnt[b] <= '0;
            end else begin
               r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
            end
         end
      end
   end

   assign w_dir_lvl = (r_dir == DIR_UP) ? r_db[0] : r_db[1];
   assign w_oth_lvl = (r_dir == DIR_UP) ? r_db[1] : r_db[0];
   assign w_abort   = !en || !w_dir_lvl || w_oth_lvl;

   // Abort is tested before the timer so it wins over a strobe due that cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_dir      <= DIR_UP;
         r_timer    <= '0;
         count_up   <= 1'b0;
         count_down <= 1'b0;
         repeating  <= 1'b0;
      end else begin
         count_up   <= 1'b0;
         count_down <= 1'b0;
         case (r_state)
            S_IDLE: begin
               repeating <= 1'b0;
               if (en && w_press[0] && !r_db[1]) begin
                  count_up <= 1'b1;
                  r_dir    <= DIR_UP;
                  r_timer  <= '0;
                  r_state  <= S_HOLD;
               end else if (en && w_press[1] && !r_db[0]) begin
                  count_down <= 1'b1;
                  r_dir      <= DIR_DOWN;
                  r_timer    <= '0;
                  r_state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (w_abort) begin
                  r_state   <= S_IDLE;
                  repeating <= 1'b0;
               end else if (r_timer == HOLD_LAST) begin
                  count_up   <= (r_dir == DIR_UP);
                  count_down <= (r_dir == DIR_DOWN);
                  r_timer    <= '0;
                  r_state    <= S_REPEAT;
                  repeating  <= 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_REPEAT: begin
               if (w_abort) begin
                  r_state   <= S_IDLE;
                  repeating <= 1'b0;
               end else if (r_timer == REP_LAST) begin
                  count_up   <= (r_dir == DIR_UP);
                  count_down <= (r_dir == DIR_DOWN);
                  r_timer    <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               repeating <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adjust_button_pulser.sv
// Scoreboard bench for adjust_button_pulser: expected strobes (edge, direction,
// repeating) are queued when a button is driven and popped as strobes appear.
module tb_adjust_button_pulser;

   localparam int D = 4;
   localparam int H = 10;
   localparam int R = 5;

   logic clk = 1'b0;
   logic reset;
   logic en;
   logic btn_up;
   logic btn_down;
   logic count_up;
   logic count_down;
   logic repeating;

   typedef struct {
      int edge_n;
      bit up;
      bit rep;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   adjust_button_pulser #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES(H),
      .REPEAT_CYCLES(R)
   ) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .count_up(count_up),
      .count_down(count_down),
      .repeating(repeating)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int e, input bit up, input bit rep);
      exp_t x;
      x.edge_n = e;
      x.up     = up;
      x.rep    = rep;
      q.push_back(x);
   endtask

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Clean press held for n cycles, driven just after edge s0. The strobe lands
   // D+3 edges later; repeats continue until the release abort edge s0+n+D+3.
   task automatic press(input bit up, input int n);
      int s0, ab, e;
      s0 = cyc;
      if (up) btn_up = 1'b1; else btn_down = 1'b1;
      ab = s0 + n + D + 3;
      if (n >= D) begin
         push(s0 + D + 3, up, 1'b0);
         e = s0 + D + 3 + H;
         while (e < ab) begin
            push(e, up, 1'b1);
            e += R;
         end
      end
      repeat (n) @(posedge clk);
      #1;
      if (up) btn_up = 1'b0; else btn_down = 1'b0;
   endtask

   always @(negedge clk) begin
      if (count_up || count_down) begin
         exp_t x;
         check("both_strobes", int'(count_up && count_down), 0);
         if (q.size() == 0) begin
            check("unexpected_strobe_edge", cyc, -1);
         end else begin
            x = q.pop_front();
            check("strobe_edge", cyc, x.edge_n);
            check("strobe_dir_up", int'(count_up), int'(x.up));
            check("strobe_repeating", int'(repeating), int'(x.rep));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      reset = 1'b1; en = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_count_up", int'(count_up), 0);
      check("rst_count_down", int'(count_down), 0);
      check("rst_repeating", int'(repeating), 0);
      reset = 1'b0;
      idle(5);

      // Hold up through HOLD into REPEAT, then release.
      press(1'b1, 21);
      idle(30);
      check("drain_hold_repeat", q.size(), 0);

      // Bounce: 2-cycle toggles never settle long enough.
      for (int i = 0; i < 10; i++) begin
         btn_up = (i % 2 == 0);
         idle(2);
      end
      btn_up = 1'b0;
      idle(20);
      check("drain_bounce", q.size(), 0);

      // Short down press: single strobe.
      press(1'b0, 8);
      idle(30);
      check("drain_down_short", q.size(), 0);

      // Up in REPEAT, then down pressed: abort with no strobe.
      s0 = cyc;
      btn_up = 1'b1;
      push(s0 + D + 3, 1'b1, 1'b0);
      push(s0 + D + 3 + H, 1'b1, 1'b1);
      push(s0 + D + 3 + H + R, 1'b1, 1'b1);
      idle(19);
      btn_down = 1'b1;
      idle(6);
      check("rep_before_abort", int'(repeating), 1);
      idle(1);
      check("rep_after_abort", int'(repeating), 0);
      btn_up = 1'b0; btn_down = 1'b0;
      idle(30);
      check("drain_other_abort", q.size(), 0);
      press(1'b0, 6);
      idle(30);
      check("drain_down_after_abort", q.size(), 0);

      // Both buttons on the same edge: nothing.
      btn_up = 1'b1; btn_down = 1'b1;
      idle(12);
      btn_up = 1'b0; btn_down = 1'b0;
      idle(20);
      check("drain_both", q.size(), 0);

      // Held while en low, then en raised: nothing until re-press.
      en = 1'b0;
      btn_up = 1'b1;
      idle(12);
      en = 1'b1;
      idle(25);
      check("en_rise_repeating", int'(repeating), 0);
      btn_up = 1'b0;
      idle(15);
      press(1'b1, 6);
      idle(30);
      check("drain_en", q.size(), 0);

      // Reset mid-REPEAT with up held.
      s0 = cyc;
      btn_up = 1'b1;
      push(s0 + D + 3, 1'b1, 1'b0);
      push(s0 + D + 3 + H, 1'b1, 1'b1);
      push(s0 + D + 3 + H + R, 1'b1, 1'b1);
      idle(23);
      check("pre_reset_repeating", int'(repeating), 1);
      reset = 1'b1;
      #1;
      check("reset_count_up", int'(count_up), 0);
      check("reset_count_down", int'(count_down), 0);
      check("reset_repeating", int'(repeating), 0);
      idle(3);
      reset = 1'b0;
      idle(D - 1);
      btn_up = 1'b0;
      idle(15);
      check("drain_reset", q.size(), 0);
      press(1'b1, 6);
      idle(30);
      check("drain_final", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
